// File: rtl/clusterv_memc_pkg.sv
// clusterv_memc_pkg
//   Shared definitions for the banked main-SRAM Wishbone target:
//   - memc_state_e : target FSM state encoding (2 bits)
//   - sel_width()  : width of the bank-select field for a given bank count
//   - mask_width() : byte-mask width for a given data width
//   - DEF_MASK_WIDTH : byte-mask width of the default 32-bit data path
package clusterv_memc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2,
        ERR     = 2'd3
    } memc_state_e;

    localparam int BYTE_WIDTH     = 8;
    localparam int DEF_DAT_WIDTH  = 32;
    localparam int DEF_MASK_WIDTH = DEF_DAT_WIDTH / BYTE_WIDTH;

    // A single bank still gets a 1-bit select field so that the address
    // slice is never zero-width.
    function automatic int sel_width(input int n_banks);
        if (n_banks <= 1) begin
            return 1;
        end else begin
            return $clog2(n_banks);
        end
    endfunction

    function automatic int mask_width(input int dat_width);
        return dat_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/clusterv_memc_bank_mux.sv
// clusterv_memc_bank_mux
//   Purely combinational fan-out / fan-in between the FSM and the SRAM macros.
//   Ports:
//     en          - drive the selected bank this cycle
//     sel_bank    - bank receiving the access
//     we          - access is a write
//     byte_sel    - Wishbone byte selects (ignored on reads)
//     word_adr    - word address inside the macro
//     dat_w       - write data
//     sram_*      - packed per-bank macro pins (bank b owns slice b)
//     rd_bank     - bank whose read data is returned
//     rd_dat      - read data of rd_bank
module clusterv_memc_bank_mux
    import clusterv_memc_pkg::*;
#(
    parameter int N_BANKS        = 4,
    parameter int BANK_ADR_WIDTH = 8,
    parameter int DAT_WIDTH      = 32,
    parameter int SEL_W          = sel_width(N_BANKS),
    parameter int MASK_W         = mask_width(DAT_WIDTH)
) (
    input  logic                                en,
    input  logic [SEL_W-1:0]                    sel_bank,
    input  logic                                we,
    input  logic [MASK_W-1:0]                   byte_sel,
    input  logic [BANK_ADR_WIDTH-1:0]           word_adr,
    input  logic [DAT_WIDTH-1:0]                dat_w,
    output logic [N_BANKS-1:0]                  sram_csb,
    output logic [N_BANKS-1:0]                  sram_web,
    output logic [N_BANKS*MASK_W-1:0]           sram_wmask,
    output logic [N_BANKS*BANK_ADR_WIDTH-1:0]   sram_addr,
    output logic [N_BANKS*DAT_WIDTH-1:0]        sram_dat_w,
    input  logic [SEL_W-1:0]                    rd_bank,
    input  logic [N_BANKS*DAT_WIDTH-1:0]        sram_dat_r,
    output logic [DAT_WIDTH-1:0]                rd_dat
);

    // One-hot drive of the selected macro; idle banks see all-inactive pins.
    always_comb begin
        sram_csb   = {N_BANKS{1'b1}};
        sram_web   = {N_BANKS{1'b1}};
        sram_wmask = {(N_BANKS*MASK_W){1'b0}};
        sram_addr  = {(N_BANKS*BANK_ADR_WIDTH){1'b0}};
        sram_dat_w = {(N_BANKS*DAT_WIDTH){1'b0}};
        for (int b = 0; b < N_BANKS; b++) begin
            if (en && (sel_bank == SEL_W'(b))) begin
                sram_csb[b] = 1'b0;
                sram_web[b] = ~we;
                // Reads must not carry a mask into the macro.
                sram_wmask[b*MASK_W +: MASK_W]                 = we ? byte_sel : {MASK_W{1'b0}};
                sram_addr[b*BANK_ADR_WIDTH +: BANK_ADR_WIDTH]  = word_adr;
                sram_dat_w[b*DAT_WIDTH +: DAT_WIDTH]           = dat_w;
            end else begin
                sram_csb[b] = 1'b1;
                sram_web[b] = 1'b1;
            end
        end
    end

    // AND-OR read mux; an index with no matching bank yields zero.
    always_comb begin
        rd_dat = {DAT_WIDTH{1'b0}};
        for (int b = 0; b < N_BANKS; b++) begin
            rd_dat = rd_dat | (sram_dat_r[b*DAT_WIDTH +: DAT_WIDTH]
                               & {DAT_WIDTH{rd_bank == SEL_W'(b)}});
        end
    end

endmodule

// File: rtl/clusterv_memc_banked.sv
// clusterv_memc_banked
//   Wishbone-tag target presenting N_BANKS single-port SRAM macros as one
//   contiguous main-SRAM region. One access per two cycles; ack/err are
//   decoded from the FSM state and suppressed when t_cyc drops (abort).
//   Optional build macro: CLUSTERV_MEMC_RDATA_REG_EN
//     defined   - reads go IDLE -> RD_WAIT -> ACK and return data from a
//                 holding register (2-cycle read latency)
//     undefined - reads return the macro output directly (1-cycle latency)
//   Ports:
//     clock, reset          - clock, asynchronous active-high reset
//     t_adr/t_dat_w/t_dat_r - byte address, write data, read data
//     t_cyc/t_stb/t_we/t_sel- Wishbone cycle, strobe, write enable, byte selects
//     t_ack/t_err           - transfer acknowledge, error acknowledge
//     t_tgc/t_tga/t_tgd_w   - tags, ignored; t_tgd_r tied low
//     sram_*                - packed per-bank macro pins (active-low csb/web)
module clusterv_memc_banked
    import clusterv_memc_pkg::*;
#(
    parameter int N_BANKS        = 4,
    parameter int BANK_ADR_WIDTH = 8,
    parameter int DAT_WIDTH      = 32,
    parameter int ADR_WIDTH      = 32
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [ADR_WIDTH-1:0]                   t_adr,
    input  logic [DAT_WIDTH-1:0]                   t_dat_w,
    output logic [DAT_WIDTH-1:0]                   t_dat_r,
    input  logic                                   t_cyc,
    input  logic                                   t_stb,
    input  logic                                   t_we,
    input  logic [DAT_WIDTH/8-1:0]                 t_sel,
    output logic                                   t_ack,
    output logic                                   t_err,
    input  logic [3:0]                             t_tgc,
    input  logic                                   t_tga,
    input  logic                                   t_tgd_w,
    output logic                                   t_tgd_r,
    output logic [N_BANKS-1:0]                     sram_csb,
    output logic [N_BANKS-1:0]                     sram_web,
    output logic [N_BANKS*(DAT_WIDTH/8)-1:0]       sram_wmask,
    output logic [N_BANKS*BANK_ADR_WIDTH-1:0]      sram_addr,
    output logic [N_BANKS*DAT_WIDTH-1:0]           sram_dat_w,
    input  logic [N_BANKS*DAT_WIDTH-1:0]           sram_dat_r
);

    localparam int             SEL_W     = sel_width(N_BANKS);
    localparam int             MASK_W    = mask_width(DAT_WIDTH);
    localparam logic [SEL_W:0] N_BANKS_L = (SEL_W+1)'(N_BANKS);

    memc_state_e                 state_r;
    memc_state_e                 state_nxt_s;
    logic [SEL_W-1:0]            bank_r;
    logic                        we_r;
    logic                        req_s;
    logic                        in_range_s;
    logic                        accept_s;
    logic                        ack_s;
    logic                        err_s;
    logic [SEL_W-1:0]            bank_s;
    logic [BANK_ADR_WIDTH-1:0]   word_adr_s;
    logic [DAT_WIDTH-1:0]        mux_dat_s;
    logic [DAT_WIDTH-1:0]        dat_r_s;
`ifdef CLUSTERV_MEMC_RDATA_REG_EN
    logic [DAT_WIDTH-1:0]        hold_r;
`endif

    // Tags and the already-decoded window bits carry no meaning here.
    logic unused_s;
    assign unused_s = ^{t_tgc, t_tga, t_tgd_w, t_adr};

    // Bits above the bank field are ignored: the interconnect decoded the window.
    assign word_adr_s = t_adr[2 +: BANK_ADR_WIDTH];
    assign bank_s     = t_adr[2+BANK_ADR_WIDTH +: SEL_W];
    assign in_range_s = ({1'b0, bank_s} < N_BANKS_L);
    // Gating with reset keeps every macro deselected while reset is held.
    assign req_s      = t_cyc & t_stb & ~reset;

    clusterv_memc_bank_mux #(
        .N_BANKS        (N_BANKS),
        .BANK_ADR_WIDTH (BANK_ADR_WIDTH),
        .DAT_WIDTH      (DAT_WIDTH),
        .SEL_W          (SEL_W),
        .MASK_W         (MASK_W)
    ) u_bank_mux (
        .en         (accept_s),
        .sel_bank   (bank_s),
        .we         (t_we),
        .byte_sel   (t_sel),
        .word_adr   (word_adr_s),
        .dat_w      (t_dat_w),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_dat_w (sram_dat_w),
        .rd_bank    (bank_r),
        .sram_dat_r (sram_dat_r),
        .rd_dat     (mux_dat_s)
    );

    // Next-state and response decode. Every non-IDLE state returns to IDLE,
    // so a strobe held across the ack is sampled again only after a full
    // IDLE visit and is never double-issued.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        ack_s       = 1'b0;
        err_s       = 1'b0;
        dat_r_s     = {DAT_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (in_range_s) begin
                        accept_s = 1'b1;
`ifdef CLUSTERV_MEMC_RDATA_REG_EN
                        if (t_we) begin
                            state_nxt_s = ACK;
                        end else begin
                            state_nxt_s = RD_WAIT;
                        end
`else
                        state_nxt_s = ACK;
`endif
                    end else begin
                        state_nxt_s = ERR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
`ifdef CLUSTERV_MEMC_RDATA_REG_EN
                if (t_cyc) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
`else
                state_nxt_s = IDLE;
`endif
            end
            ACK: begin
                state_nxt_s = IDLE;
                if (t_cyc) begin
                    ack_s = 1'b1;
                    if (!we_r) begin
`ifdef CLUSTERV_MEMC_RDATA_REG_EN
                        dat_r_s = hold_r;
`else
                        dat_r_s = mux_dat_s;
`endif
                    end else begin
                        dat_r_s = {DAT_WIDTH{1'b0}};
                    end
                end else begin
                    ack_s = 1'b0;
                end
            end
            ERR: begin
                state_nxt_s = IDLE;
                err_s       = t_cyc;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bank index and direction of the accepted access, used during ACK.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_r <= {SEL_W{1'b0}};
            we_r   <= 1'b0;
        end else if (accept_s) begin
            bank_r <= bank_s;
            we_r   <= t_we;
        end else begin
            bank_r <= bank_r;
            we_r   <= we_r;
        end
    end

`ifdef CLUSTERV_MEMC_RDATA_REG_EN
    // Read-data holding register, loaded while the macro output is valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_r <= {DAT_WIDTH{1'b0}};
        end else if (state_r == RD_WAIT) begin
            hold_r <= mux_dat_s;
        end else begin
            hold_r <= hold_r;
        end
    end
`endif

    assign t_ack   = ack_s;
    assign t_err   = err_s;
    assign t_dat_r = dat_r_s;
    assign t_tgd_r = 1'b0;

endmodule

// File: tb/tb_clusterv_memc_banked.sv
// Bench for clusterv_memc_banked: a 4-bank instance backed by behavioural
// SRAM macros, plus a 3-bank instance for the out-of-range error path.
module tb_clusterv_memc_banked;

    localparam int NB  = 4;
    localparam int BAW = 8;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MW  = DW / 8;
`ifdef CLUSTERV_MEMC_RDATA_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [AW-1:0]     t_adr = 32'h0;
    logic [DW-1:0]     t_dat_w = 32'h0;
    logic              t_cyc = 1'b0;
    logic              t_stb = 1'b0;
    logic              t_we  = 1'b0;
    logic [MW-1:0]     t_sel = 4'h0;
    logic [3:0]        t_tgc = 4'h0;
    logic              t_tga = 1'b0;
    logic              t_tgd_w = 1'b0;

    logic [DW-1:0]     t_dat_r;
    logic              t_ack, t_err, t_tgd_r;
    logic [NB-1:0]     sram_csb, sram_web;
    logic [NB*MW-1:0]  sram_wmask;
    logic [NB*BAW-1:0] sram_addr;
    logic [NB*DW-1:0]  sram_dat_w;
    logic [NB*DW-1:0]  sram_dat_r;

    logic [DW-1:0]     d3_dat_r;
    logic              d3_ack, d3_err, d3_tgd_r;
    logic [2:0]        d3_csb, d3_web;
    logic [3*MW-1:0]   d3_wmask;
    logic [3*BAW-1:0]  d3_addr;
    logic [3*DW-1:0]   d3_dat_w;
    logic [3*DW-1:0]   d3_sram_dat_r = 96'h0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];

    always #5 clock = ~clock;

    clusterv_memc_banked #(.N_BANKS(NB), .BANK_ADR_WIDTH(BAW), .DAT_WIDTH(DW), .ADR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_ack(t_ack), .t_err(t_err),
        .t_tgc(t_tgc), .t_tga(t_tga), .t_tgd_w(t_tgd_w), .t_tgd_r(t_tgd_r),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_dat_w(sram_dat_w), .sram_dat_r(sram_dat_r)
    );

    clusterv_memc_banked #(.N_BANKS(3), .BANK_ADR_WIDTH(BAW), .DAT_WIDTH(DW), .ADR_WIDTH(AW)) dut3 (
        .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(d3_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_ack(d3_ack), .t_err(d3_err),
        .t_tgc(t_tgc), .t_tga(t_tga), .t_tgd_w(t_tgd_w), .t_tgd_r(d3_tgd_r),
        .sram_csb(d3_csb), .sram_web(d3_web), .sram_wmask(d3_wmask),
        .sram_addr(d3_addr), .sram_dat_w(d3_dat_w), .sram_dat_r(d3_sram_dat_r)
    );

    // Behavioural RW macros: capture on the clock edge, output held until next read.
    logic [DW-1:0] mem [NB][256];
    logic [DW-1:0] dout [NB];

    initial begin
        for (int b = 0; b < NB; b++) begin
            dout[b] = 32'h0;
            for (int a = 0; a < 256; a++) mem[b][a] = 32'h0;
        end
    end

    always @(posedge clock) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb[b]) begin
                if (!sram_web[b]) begin
                    for (int k = 0; k < MW; k++) begin
                        if (sram_wmask[b*MW+k])
                            mem[b][sram_addr[b*BAW +: BAW]][k*8 +: 8] <= sram_dat_w[b*DW + k*8 +: 8];
                    end
                end else begin
                    dout[b] <= mem[b][sram_addr[b*BAW +: BAW]];
                end
            end
        end
    end

    always_comb begin
        sram_dat_r = {(NB*DW){1'b0}};
        for (int b = 0; b < NB; b++) sram_dat_r[b*DW +: DW] = dout[b];
    end

    typedef struct {
        logic          we;
        logic [31:0]   adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        int            bank;
        logic [7:0]    waddr;
        logic [31:0]   exp_r;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete access: check the macro drive, latency, then scoreboard data.
    task automatic do_access(input vec_t v);
        int         lat;
        logic       got;
        logic [3:0] ecsb;
        logic [DW-1:0] exp_d;
        @(posedge clock); #1;
        t_adr = v.adr; t_dat_w = v.dat; t_sel = v.sel; t_we = v.we;
        t_cyc = 1'b1; t_stb = 1'b1;
        exp_q.push_back(v.we ? 32'h0 : v.exp_r);
        ecsb = 4'hF;
        ecsb[v.bank] = 1'b0;
        @(negedge clock);
        check("req_csb", {60'h0, sram_csb}, {60'h0, ecsb});
        check("req_web", {63'h0, sram_web[v.bank]}, {63'h0, ~v.we});
        check("req_wmask", {60'h0, sram_wmask[v.bank*MW +: MW]}, {60'h0, (v.we ? v.sel : 4'h0)});
        check("req_addr", {56'h0, sram_addr[v.bank*BAW +: BAW]}, {56'h0, v.waddr});
        if (v.we) check("req_datw", {32'h0, sram_dat_w[v.bank*DW +: DW]}, {32'h0, v.dat});
        check("req_noack", {63'h0, t_ack}, 64'h0);
        @(posedge clock);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clock);
            lat++;
            if (t_ack || t_err) got = 1'b1;
        end
        check("ack_seen", {63'h0, got}, 64'h1);
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        if (got) begin
            check("latency", 64'(lat), 64'(v.we ? 1 : RD_LAT));
            check("no_err", {63'h0, t_err}, 64'h0);
            check("ack_csb", {60'h0, sram_csb}, 64'hF);
            check("rdata", {32'h0, t_dat_r}, {32'h0, exp_d});
        end
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         strobes;
        int         acks;
        logic [3:0] pattern;
        vec_t       v;

        vecs[0]  = '{1'b1, 32'h8000_0C04, 32'hDEAD_BEEF, 4'hF, 3, 8'h01, 32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0C04, 32'h0,         4'hF, 3, 8'h01, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'hAABB_CCDD, 4'hF, 0, 8'h00, 32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'h4, 0, 8'h00, 32'h0};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0,         4'hF, 0, 8'h00, 32'hAA22_CCDD};
        vecs[5]  = '{1'b1, 32'h8000_0404, 32'h1234_5678, 4'hF, 1, 8'h01, 32'h0};
        vecs[6]  = '{1'b1, 32'h8000_0808, 32'hCAFE_F00D, 4'h3, 2, 8'h02, 32'h0};
        vecs[7]  = '{1'b0, 32'h8000_0808, 32'h0,         4'hF, 2, 8'h02, 32'h0000_F00D};
        vecs[8]  = '{1'b0, 32'h8000_0404, 32'h0,         4'hF, 1, 8'h01, 32'h1234_5678};
        vecs[9]  = '{1'b1, 32'h8000_0404, 32'hFFFF_FFFF, 4'h0, 1, 8'h01, 32'h0};
        vecs[10] = '{1'b0, 32'h8000_0404, 32'h0,         4'hF, 1, 8'h01, 32'h1234_5678};
        vecs[11] = '{1'b1, 32'h8000_07FC, 32'h0BAD_C0DE, 4'hF, 1, 8'hFF, 32'h0};
        vecs[12] = '{1'b0, 32'h8000_07FC, 32'h0,         4'hF, 1, 8'hFF, 32'h0BAD_C0DE};
        vecs[13] = '{1'b0, 32'hFFFF_0C04, 32'h0,         4'hF, 3, 8'h01, 32'hDEAD_BEEF};

        t_tgc   = 4'($urandom_range(15, 0));
        t_tga   = 1'($urandom_range(1, 0));
        t_tgd_w = 1'($urandom_range(1, 0));

        // Reset values.
        #2;
        check("rst_ack", {63'h0, t_ack}, 64'h0);
        check("rst_err", {63'h0, t_err}, 64'h0);
        check("rst_datr", {32'h0, t_dat_r}, 64'h0);
        check("rst_tgdr", {63'h0, t_tgd_r}, 64'h0);
        check("rst_csb", {60'h0, sram_csb}, 64'hF);
        check("rst_web", {60'h0, sram_web}, 64'hF);
        check("rst_wmask", {48'h0, sram_wmask}, 64'h0);
        check("rst_addr", {32'h0, sram_addr}, 64'h0);
        check("rst_datw", {63'h0, (sram_dat_w != 128'h0)}, 64'h0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven accesses.
        for (int i = 0; i < 14; i++) do_access(vecs[i]);

        // Out-of-range bank on the 3-bank instance.
        @(posedge clock); #1;
        t_adr = 32'h8000_0C00; t_we = 1'b0; t_sel = 4'hF; t_cyc = 1'b1; t_stb = 1'b1;
        @(negedge clock);
        check("oor_req_csb", {61'h0, d3_csb}, 64'h7);
        check("oor_req_err", {63'h0, d3_err}, 64'h0);
        @(negedge clock);
        check("oor_err", {63'h0, d3_err}, 64'h1);
        check("oor_ack", {63'h0, d3_ack}, 64'h0);
        check("oor_csb", {61'h0, d3_csb}, 64'h7);
        check("oor_datr", {32'h0, d3_dat_r}, 64'h0);
        @(negedge clock);
        check("oor_err_once", {63'h0, d3_err}, 64'h0);
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0;
        repeat (3) @(posedge clock);

        // Held strobe across the ack: one strobe per IDLE visit.
        @(posedge clock); #1;
        t_adr = 32'h8000_0C08; t_dat_w = 32'h55AA_55AA; t_sel = 4'hF; t_we = 1'b1;
        t_cyc = 1'b1; t_stb = 1'b1;
        strobes = 0;
        pattern = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pattern[i] = t_ack;
            if (!sram_csb[3]) strobes++;
            @(posedge clock);
        end
        #1;
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        check("held_ack_pattern", {60'h0, pattern}, 64'hA);
        check("held_strobes", 64'(strobes), 64'h2);
        v = '{1'b0, 32'h8000_0C08, 32'h0, 4'hF, 3, 8'h02, 32'h55AA_55AA};
        do_access(v);

        // Abort: cyc dropped right after a read is accepted.
        @(posedge clock); #1;
        t_adr = 32'h8000_0C04; t_we = 1'b0; t_cyc = 1'b1; t_stb = 1'b1;
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (t_ack || t_err) acks++;
        end
        check("abort_no_ack", 64'(acks), 64'h0);
        v = '{1'b1, 32'h8000_0400, 32'hA5A5_0001, 4'hF, 1, 8'h00, 32'h0};
        do_access(v);
        v = '{1'b0, 32'h8000_0400, 32'h0, 4'hF, 1, 8'h00, 32'hA5A5_0001};
        do_access(v);

        // Reset asserted in the ACK cycle with the bus still requesting.
        @(posedge clock); #1;
        t_adr = 32'h8000_0C0C; t_dat_w = 32'h0000_0077; t_sel = 4'hF; t_we = 1'b1;
        t_cyc = 1'b1; t_stb = 1'b1;
        @(posedge clock); #1;
        check("pre_reset_ack", {63'h0, t_ack}, 64'h1);
        reset = 1'b1;
        #1;
        check("reset_ack", {63'h0, t_ack}, 64'h0);
        check("reset_csb", {60'h0, sram_csb}, 64'hF);
        check("reset_datr", {32'h0, t_dat_r}, 64'h0);
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        v = '{1'b0, 32'h8000_0C0C, 32'h0, 4'hF, 3, 8'h03, 32'h0000_0077};
        do_access(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clusterv_memc_banked.md
Name: clusterv_memc_banked

Overview:
- Parametrised Wishbone-tag target that fronts N_BANKS sky130 OpenRAM RW macros as one contiguous main-SRAM region.
- Replaces the stubbed main-SRAM target on the core interconnect (0x8000_0000 window).
- Decodes the bank, drives one macro per access, returns registered ack/err and muxed read data.
- Adds out-of-range error response, cycle abort and optional read-data pipelining.

Parameters:
N_BANKS, 4, number of SRAM macros (1..8, need not be a power of two)
BANK_ADR_WIDTH, 8, word-address width of each macro
DAT_WIDTH, 32, data width; fixed multiple of 8; byte-mask width DAT_WIDTH/8
ADR_WIDTH, 32, Wishbone address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
t_adr  in  ADR_WIDTH  byte address
t_dat_w  in  DAT_WIDTH  write data
t_dat_r  out  DAT_WIDTH  read data
t_cyc  in  1  bus cycle
t_stb  in  1  strobe
t_we  in  1  write enable
t_sel  in  DAT_WIDTH/8  byte selects
t_ack  out  1  transfer acknowledge
t_err  out  1  error acknowledge
t_tgc  in  4  cycle tag, ignored
t_tga  in  1  address tag, ignored
t_tgd_w  in  1  write-data tag, ignored
t_tgd_r  out  1  read-data tag, tied 0
sram_csb  out  N_BANKS  per-bank chip select, active low
sram_web  out  N_BANKS  per-bank write enable, active low
sram_wmask  out  N_BANKS*DAT_WIDTH/8  per-bank byte mask
sram_addr  out  N_BANKS*BANK_ADR_WIDTH  per-bank word address
sram_dat_w  out  N_BANKS*DAT_WIDTH  per-bank write data
sram_dat_r  in  N_BANKS*DAT_WIDTH  per-bank read data

Behaviour:
- Single clock domain, clock. reset is asynchronous, active-high.
- Reset values:
  - State: IDLE.
  - sram_csb: all 1. sram_web: all 1.
  - sram_wmask, sram_addr, sram_dat_w: 0.
  - t_ack, t_err, t_dat_r, t_tgd_r: 0.
- Reset asserted mid-access: return to IDLE immediately; no ack or err is issued afterwards.
- Address decode:
  - Word address = t_adr[2 +: BANK_ADR_WIDTH].
  - bank = t_adr[2+BANK_ADR_WIDTH +: SEL_W], SEL_W = clog2(N_BANKS), minimum 1.
  - Higher address bits are ignored; the interconnect has already decoded the window.
- Macro drive: in IDLE with t_cyc & t_stb & bank < N_BANKS:
  - Combinationally drive the selected bank: csb=0, web=!t_we, wmask=t_sel (forced 0 on reads), addr, dat_w.
  - All other banks: csb=1.
  - Latch bank index and t_we; go to ACK.
- Out-of-range bank (bank >= N_BANKS): no macro is selected; go to ERR.
- ACK state:
  - t_ack=1 for exactly one cycle; every csb=1.
  - Reads: t_dat_r = sram_dat_r of the latched bank. Writes: t_dat_r = 0.
  - Next state IDLE.
- ERR state: t_err=1 for one cycle, t_dat_r=0, next state IDLE.
- Latency and throughput:
  - Write or read ack arrives 1 cycle after the request is accepted.
  - One access per 2 cycles. IDLE is re-entered before the next request is sampled, so a held stb is never double-issued.
- Writes with t_sel=0: the macro is still accessed with wmask=0 and the write is acked.
- Abort: if t_cyc is low in ACK, RD_WAIT or ERR, suppress ack/err and go to IDLE. A write already strobed stays committed.
- t_stb low in IDLE: no access; outputs stay at their idle values.

Optional Feature:
CLUSTERV_MEMC_RDATA_REG_EN:
- Defined: reads pass IDLE -> RD_WAIT -> ACK.
  - RD_WAIT registers the latched bank's sram_dat_r into a holding register.
  - ACK drives t_dat_r from that register. Read ack latency becomes 2 cycles.
  - Writes are unchanged at 1 cycle.
- Undefined: the RD_WAIT state and holding register are absent; read latency is 1 cycle.

Decomposition:
- Package clusterv_memc_pkg holds:
  - state enum {IDLE, RD_WAIT, ACK, ERR}, 2 bits;
  - localparam function for SEL_W;
  - DAT_WIDTH/8 mask-width constant.
- Sub-module clusterv_memc_bank_mux: purely combinational. Does one-hot bank select to csb/web/wmask fan-out, and read-data mux by bank index.
- FSM lives in the top.

Test Plan:
All scenarios run with N_BANKS=4 and BANK_ADR_WIDTH=8.
1. Write then read, bank 3:
   - Write 0xDEADBEEF to 0x8000_0C04 with sel=0xF: bank 3 sees csb=0, web=0, addr=0x01; t_ack one cycle later.
   - Read of the same address acks with t_dat_r=0xDEADBEEF after 1 cycle, or 2 cycles with CLUSTERV_MEMC_RDATA_REG_EN.
2. Byte write: write 0x11223344 with sel=0x4 to 0x8000_0000 over existing 0xAABBCCDD; readback is 0xAA22CCDD.
3. Out-of-range bank: build with N_BANKS=3, access 0x8000_0C00 -> t_err=1 for one cycle, t_ack=0, all csb stay 1.
4. Held strobe: hold cyc/stb across ack for 3 extra cycles -> exactly one macro strobe per IDLE visit, ack pattern 0,1,0,1.
5. Abort: drop cyc in the cycle after a read is accepted -> no ack; the next write to 0x8000_0400 completes normally.
6. Reset mid-op: assert reset in the ACK cycle -> t_ack=0 and csb=0xF immediately; the first access after reset completes with normal latency.
